// File: rtl/barrier_servo_ctrl.sv
// Parking barrier servo driver: slewed 50 Hz PWM, hold-open timer, obstruction reversal.
// Optional pass counter enabled by defining PASS_COUNT_EN; otherwise car_count reads 0.
module barrier_servo_ctrl #(
  parameter int PWM_PERIOD_CYC   = 200000,
  parameter int PULSE_CLOSED_CYC = 10000,
  parameter int PULSE_OPEN_CYC   = 20000,
  parameter int SLEW_STEP_CYC    = 500,
  parameter int HOLD_OPEN_FRAMES = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       open_req,
  input  logic       car_present,
  output logic       pwm_out,
  output logic       is_closed,
  output logic       is_open,
  output logic       busy,
  output logic [7:0] car_count
);

  localparam int W  = $clog2(PWM_PERIOD_CYC) + 1;
  localparam int HW = (HOLD_OPEN_FRAMES < 1) ? 1 : $clog2(HOLD_OPEN_FRAMES + 1);

  localparam logic [W-1:0]  CNT_LAST  = W'(PWM_PERIOD_CYC - 1);
  localparam logic [W-1:0]  PW_CLOSED = W'(PULSE_CLOSED_CYC);
  localparam logic [W-1:0]  PW_OPEN   = W'(PULSE_OPEN_CYC);
  localparam logic [W:0]    STEP_X    = (W+1)'(SLEW_STEP_CYC);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_OPEN_FRAMES);

  typedef enum logic [1:0] {
    CLOSED    = 2'd0,
    OPENING   = 2'd1,
    OPEN_HOLD = 2'd2,
    CLOSING   = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [W-1:0]  cnt, cnt_n;
  logic [W-1:0]  pw, pw_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic          run;
  logic          req_m, req_s, car_m, car_s;
  logic          frame_end;
  logic [W:0]    up_sum;
  logic [W-1:0]  pw_up, pw_dn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_m <= 1'b0;
      req_s <= 1'b0;
      car_m <= 1'b0;
      car_s <= 1'b0;
    end else begin
      req_m <= open_req;
      req_s <= req_m;
      car_m <= car_present;
      car_s <= car_m;
    end
  end

  assign frame_end = (cnt == CNT_LAST);

  // Counter is held at 0 for the first cycle after reset so the first pulse covers cnt=0.
  always_comb begin
    cnt_n = cnt + W'(1);
    if (!run || frame_end) cnt_n = '0;
  end

  assign up_sum = {1'b0, pw} + STEP_X;
  assign pw_up  = (up_sum >= {1'b0, PW_OPEN}) ? PW_OPEN : up_sum[W-1:0];
  assign pw_dn  = ({1'b0, pw} >= ({1'b0, PW_CLOSED} + STEP_X)) ? (pw - STEP_X[W-1:0]) : PW_CLOSED;

  always_comb begin
    state_n = state;
    pw_n    = pw;
    hold_n  = hold_cnt;
    case (state)
      CLOSED: begin
        if (req_s) state_n = OPENING;
      end
      OPENING: begin
        if (frame_end) begin
          pw_n = pw_up;
          if (pw_up == PW_OPEN) begin
            state_n = OPEN_HOLD;
            hold_n  = HOLD_LOAD;
          end
        end
      end
      OPEN_HOLD: begin
        if (req_s || car_s)      hold_n  = HOLD_LOAD;
        else if (hold_cnt == '0) state_n = CLOSING;
        else if (frame_end)      hold_n  = hold_cnt - HW'(1);
      end
      CLOSING: begin
        // Reversal wins over a same-cycle arrival at the closed endpoint.
        if (req_s || car_s) begin
          state_n = OPENING;
        end else if (frame_end) begin
          pw_n = pw_dn;
          if (pw_dn == PW_CLOSED) state_n = CLOSED;
        end
      end
      default: state_n = CLOSED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= CLOSED;
      pw       <= PW_CLOSED;
      hold_cnt <= '0;
      cnt      <= '0;
      run      <= 1'b0;
      pwm_out  <= 1'b0;
    end else begin
      state    <= state_n;
      pw       <= pw_n;
      hold_cnt <= hold_n;
      cnt      <= cnt_n;
      run      <= 1'b1;
      pwm_out  <= (cnt_n < pw_n);
    end
  end

  assign is_closed = (state == CLOSED);
  assign is_open   = (state == OPEN_HOLD);
  assign busy      = (state == OPENING) || (state == CLOSING);

`ifdef PASS_COUNT_EN
  logic       car_d;
  logic [7:0] pass_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      car_d    <= 1'b0;
      pass_cnt <= 8'd0;
    end else begin
      car_d <= car_s;
      if (car_d && !car_s && (state == OPEN_HOLD || state == CLOSING))
        pass_cnt <= pass_cnt + 8'd1;
    end
  end

  assign car_count = pass_cnt;
`else
  assign car_count = 8'd0;
`endif

endmodule
